// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// mix_columns_seq : sequential AES MixColumns / InvMixColumns, 1/2/4 cols/cycle
// Revision 1.0
// ============================================================================
module mix_columns_seq #(
  parameter int p_COLS_PER_CYCLE = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [0:127] i_data,
  input  logic         i_inverse,
  input  logic         i_bypass,
  output logic         o_busy,
  output logic         o_valid,
  output logic [0:127] o_data
);

  localparam int GROUPS = 4 / p_COLS_PER_CYCLE;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  localparam logic [1:0] s_IDLE    = 2'd0;
  localparam logic [1:0] s_COMPUTE = 2'd1;
  localparam logic [1:0] s_DONE    = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] col_cnt;
  logic [0:127]     data_cap;
  logic             inv_cap;
  logic             byp_cap;

  logic [1:0]  col_base;
  logic [1:0]  col_idx [p_COLS_PER_CYCLE];
  logic [31:0] col_res [p_COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[31:24] is row 0; multiples 9/b/d/e are built from the 2/4/8 chain
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  r;
    logic [31:0] res;
    int j1, j2, j3;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*(3-i) +: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      j1 = (i + 1) % 4;
      j2 = (i + 2) % 4;
      j3 = (i + 3) % 4;
      if (!inv)
        r = x2[i] ^ (x2[j1] ^ a[j1]) ^ a[j2] ^ a[j3];
      else
        r = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[j1] ^ x2[j1] ^ a[j1]) ^
            (x8[j2] ^ x4[j2] ^ a[j2]) ^ (x8[j3] ^ a[j3]);
      res[8*(3-i) +: 8] = r;
    end
    return res;
  endfunction

  if (p_COLS_PER_CYCLE != 1 && p_COLS_PER_CYCLE != 2 && p_COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: p_COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // First column of the group selected by the counter
  if (p_COLS_PER_CYCLE == 1) begin : g_base_p1
    assign col_base = col_cnt;
  end else if (p_COLS_PER_CYCLE == 2) begin : g_base_p2
    assign col_base = {col_cnt[0], 1'b0};
  end else begin : g_base_p4
    assign col_base = 2'b00;
  end

  for (genvar g = 0; g < p_COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_base | 2'(g);
    assign col_res[g] = mix_column(data_cap[{col_idx[g], 5'b0} +: 32], inv_cap);
  end

  assign o_busy = (state != s_IDLE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= s_IDLE;
      col_cnt  <= '0;
      data_cap <= '0;
      inv_cap  <= 1'b0;
      byp_cap  <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        s_IDLE: begin
          if (i_start) begin
            data_cap <= i_data;
            inv_cap  <= i_inverse;
            byp_cap  <= i_bypass;
            col_cnt  <= '0;
            if (i_bypass) begin
              o_data  <= i_data;
              o_valid <= 1'b1;
              state   <= s_DONE;
            end else begin
              state <= s_COMPUTE;
            end
          end
        end
        s_COMPUTE: begin
          if (!byp_cap) begin
            for (int g = 0; g < p_COLS_PER_CYCLE; g++)
              o_data[{col_idx[g], 5'b0} +: 32] <= col_res[g];
          end
          if (col_cnt == LAST_GRP) begin
            col_cnt <= '0;
            o_valid <= 1'b1;
            state   <= s_DONE;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        s_DONE:  state <= s_IDLE;
        default: state <= s_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
